fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// rapid_pkg
//   Shared core-wide constants. XLEN is the datapath width of every stage.
// -----------------------------------------------------------------------------
package rapid_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly in front of the decoder. It owns
//   the program counter and issues sequential word reads to instruction memory.
//   Returned words go into a small FIFO, and the FIFO head is offered to the
//   decoder as {instruction, pc}. A redirect from execute restarts fetch at the
//   new target. Every word fetched before the redirect is thrown away, whether
//   it is already buffered or still in flight.
//
//   Handshake semantics (used on every channel of this block):
//     A transfer happens on a rising clock edge when the producer's valid and
//     the consumer's ready are both high in that cycle. Once valid is raised,
//     the producer holds the payload stable until the transfer happens.
//     o_imem_req_valid and o_instr_valid are functions of registers only.
//     The memory response channel has no ready signal, so every cycle with
//     i_imem_rsp_valid high delivers exactly one word.
//
//   Parameters
//     RESET_PC  first fetch address after reset
//     DEPTH     FIFO entries, which is also the maximum number of outstanding
//               requests. Must be a power of two and at least 2.
//
//   Ports
//     i_clk, i_rst_n        clock and asynchronous active-low reset
//     o_imem_req_valid      fetch request valid (credit available)
//     i_imem_req_ready      memory accepts the request
//     o_imem_req_addr       word-aligned fetch address (current PC)
//     i_imem_rsp_valid      in-order read data valid; cannot be stalled
//     i_imem_rsp_data       instruction word
//     i_redirect_valid      single-cycle redirect pulse from execute
//     i_redirect_pc         redirect target; bits [1:0] are ignored
//     o_instr_valid         FIFO head valid
//     i_instr_ready         decoder accepts the head
//     o_instruction         FIFO head word
//     o_pc                  address of o_instruction
// -----------------------------------------------------------------------------
module fetch_unit
  import rapid_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,

  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,

  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,

  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc
);

  // CW holds 0..DEPTH. PW indexes the FIFO storage.
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_q, pc_d;                   // next request address
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;           // address of next expected response
  logic [CW-1:0]   outstanding_q, outstanding_d; // accepted, not yet answered
  logic [CW-1:0]   discard_q, discard_d;         // responses still to be dropped
  logic [CW-1:0]   count_q, count_d;             // FIFO occupancy
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] wpc_q  [DEPTH];

  // ---------------------------------------------------------------------------
  // Fire events
  // ---------------------------------------------------------------------------
  logic            req_fire;
  logic            rsp_fire;
  logic            deq;
  logic            push;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_tgt;

  // Credits count FIFO entries plus requests in flight. A request is only
  // issued when a slot is guaranteed, so a response can always be written.
  // Stale requests still hold credits until their responses come back.
  assign credit_used      = {1'b0, count_q} + {1'b0, outstanding_q};
  assign o_imem_req_valid = (credit_used < DEPTH_W);
  assign o_imem_req_addr  = pc_q;

  assign req_fire = o_imem_req_valid & i_imem_req_ready;
  assign rsp_fire = i_imem_rsp_valid;
  assign deq      = o_instr_valid & i_instr_ready;

  // Mask the byte-offset bits while using the whole input bus.
  assign redirect_tgt = i_redirect_pc & ~XLEN'(3);

  // A response is kept only outside a redirect cycle and after every stale
  // response has been drained.
  assign push = rsp_fire & ~i_redirect_valid & (discard_q == '0);

  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    discard_d = discard_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (i_redirect_valid) begin
      pc_d     = redirect_tgt;
      rsp_pc_d = redirect_tgt;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Everything still in flight at the end of this cycle is stale. That
      // includes a request accepted now (it carries the old address) and any
      // response already marked for dropping. So the discard count becomes
      // the new outstanding count. This keeps discard_q <= outstanding_q,
      // even for back-to-back redirects.
      discard_d = outstanding_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + WORD_BYTES;
      end

      if (rsp_fire) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + WORD_BYTES;
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      unique case ({push, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. It is cleared on reset so the head reads 0 while empty out
  // of reset. A flush only moves the pointers; stale contents stay behind
  // o_instr_valid = 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else if (push) begin
      word_q[wr_ptr_q] <= i_imem_rsp_data;
      wpc_q[wr_ptr_q]  <= rsp_pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder-facing outputs: registers only. A redirect takes effect on the
  // next cycle through count_q; the downstream stage squashes a same-cycle
  // dequeue itself.
  // ---------------------------------------------------------------------------
  assign o_instr_valid = (count_q != '0);
  assign o_instruction = word_q[rd_ptr_q];
  assign o_pc          = wpc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (DEPTH=4, RESET_PC=0).
//
//   The bench models instruction memory. It keeps an in-order queue of
//   accepted requests, each answered after a configurable latency with a data
//   word computed from its address. The bench also acts as the decoder. Each
//   scenario pushes the pc sequence it expects into exp_q. Every dequeue pops
//   one entry and compares it with o_pc and o_instruction. Inputs are driven
//   and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int W = rapid_pkg::XLEN;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         i_clk;
  logic         i_rst_n;
  logic         o_imem_req_valid;
  logic         i_imem_req_ready;
  logic [W-1:0] o_imem_req_addr;
  logic         i_imem_rsp_valid;
  logic [W-1:0] i_imem_rsp_data;
  logic         i_redirect_valid;
  logic [W-1:0] i_redirect_pc;
  logic         o_instr_valid;
  logic         i_instr_ready;
  logic [W-1:0] o_instruction;
  logic [W-1:0] o_pc;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_instr_valid    (o_instr_valid),
    .i_instr_ready    (i_instr_ready),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           lat = 1;        // memory latency in cycles (>= 1)
  int           mem_pct = 100;  // chance of memory ready per cycle
  int           dec_pct = 100;  // chance of decoder ready per cycle
  bit           dec_en = 1'b0;
  bit           last_rsp;
  bit           last_fire;
  int           n_fire = 0;
  int           first_fire = -1;

  logic [W-1:0] pend_addr_q[$];
  int           pend_due_q[$];
  logic [W-1:0] exp_q[$];       // scoreboard: expected pc sequence
  int           deq_cyc_q[$];

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Called right after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input bit redir, input logic [W-1:0] rpc);
    logic         rsp_v;
    logic [W-1:0] rsp_d;
    logic         req_rdy;
    logic         ins_rdy;
    logic [W-1:0] e;
    rsp_v     = 1'b0;
    rsp_d     = '0;
    last_rsp  = 1'b0;
    last_fire = 1'b0;
    if (i_rst_n && pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = mem_word(pend_addr_q.pop_front());
      void'(pend_due_q.pop_front());
      last_rsp = 1'b1;
    end
    req_rdy = i_rst_n && ($urandom_range(1, 100) <= mem_pct);
    if (req_rdy && o_imem_req_valid) begin
      pend_addr_q.push_back(o_imem_req_addr);
      pend_due_q.push_back(cyc + lat);
      last_fire = 1'b1;
      n_fire++;
      if (first_fire < 0) first_fire = cyc;
    end
    ins_rdy = dec_en && (exp_q.size() > 0) && ($urandom_range(1, 100) <= dec_pct);
    if (ins_rdy && o_instr_valid) begin
      e = exp_q.pop_front();
      n_checks++;
      if (o_pc !== e || o_instruction !== mem_word(e)) begin
        n_errors++;
        $display("FAIL deq: got pc=%h word=%h, expected pc=%h word=%h",
                 o_pc, o_instruction, e, mem_word(e));
      end
      deq_cyc_q.push_back(cyc);
    end
    i_imem_req_ready = req_rdy;
    i_imem_rsp_valid = rsp_v;
    i_imem_rsp_data  = rsp_d;
    i_instr_ready    = ins_rdy;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic assert_reset();
    i_rst_n          = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_instr_ready    = 1'b0;
    pend_addr_q.delete();
    pend_due_q.delete();
    exp_q.delete();
    deq_cyc_q.delete();
    n_fire     = 0;
    first_fire = -1;
    repeat (2) begin
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    assert_reset();
    i_rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, output int left);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1'b0, '0);
      n++;
    end
    left = exp_q.size();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    assert_reset();
    n_checks++;
    if (o_instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_instr_valid: got %b, expected 0", o_instr_valid);
    end
    n_checks++;
    if (o_instruction !== '0) begin
      n_errors++; $display("FAIL reset_instruction: got %h, expected 0", o_instruction);
    end
    n_checks++;
    if (o_pc !== '0) begin
      n_errors++; $display("FAIL reset_pc: got %h, expected 0", o_pc);
    end
    n_checks++;
    if (o_imem_req_valid !== 1'b1) begin
      n_errors++; $display("FAIL reset_req_valid: got %b, expected 1", o_imem_req_valid);
    end
    n_checks++;
    if (o_imem_req_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_req_addr: got %h, expected 0", o_imem_req_addr);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int left;
    lat = 1; mem_pct = 100; dec_pct = 100; dec_en = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * i));
    drain(100, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL stream_drain: %0d left, expected 0", left);
    end
    n_checks++;
    if (deq_cyc_q.size() != 16) begin
      n_errors++; $display("FAIL stream_count: got %0d deqs, expected 16", deq_cyc_q.size());
    end
    for (int i = 0; i < deq_cyc_q.size(); i++) begin
      n_checks++;
      if (deq_cyc_q[i] != first_fire + 2 + i) begin
        n_errors++;
        $display("FAIL stream_timing[%0d]: deq cycle %0d, expected %0d", i, deq_cyc_q[i], first_fire + 2 + i);
      end
    end
  endtask

  task automatic test_stall();
    int left;
    int rel;
    lat = 1; mem_pct = 100; dec_pct = 100; dec_en = 1'b0;
    do_reset();
    repeat (20) tick(1'b0, '0);
    n_checks++;
    if (n_fire != 4) begin
      n_errors++; $display("FAIL stall_req_count: got %0d, expected 4", n_fire);
    end
    n_checks++;
    if (o_imem_req_valid !== 1'b0) begin
      n_errors++; $display("FAIL stall_req_valid: got %b, expected 0", o_imem_req_valid);
    end
    dec_en = 1'b1;
    rel = cyc;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    drain(100, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL stall_drain: %0d left, expected 0", left);
    end
    for (int i = 0; i < 4 && i < deq_cyc_q.size(); i++) begin
      n_checks++;
      if (deq_cyc_q[i] != rel + i) begin
        n_errors++; $display("FAIL stall_gap[%0d]: deq cycle %0d, expected %0d", i, deq_cyc_q[i], rel + i);
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    int left;
    lat = 3; mem_pct = 100; dec_pct = 100; dec_en = 1'b0;
    do_reset();
    repeat (4) tick(1'b0, '0);
    n_checks++;
    if (pend_addr_q.size() != 3 || o_instr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL redir_setup: outstanding=%0d valid=%b, expected 3 and 1", pend_addr_q.size(), o_instr_valid);
    end
    tick(1'b1, 32'h0000_0100);
    n_checks++;
    if (o_instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL redir_flush: valid=%b, expected 0", o_instr_valid);
    end
    n_checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL redir_req: valid=%b addr=%h, expected 1 and 00000100", o_imem_req_valid, o_imem_req_addr);
    end
    dec_en = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drain(100, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL redir_drain: %0d left, expected 0", left);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int left;
    lat = 1; mem_pct = 100; dec_pct = 100; dec_en = 1'b0;
    do_reset();
    tick(1'b0, '0);
    tick(1'b1, 32'h0000_0203);
    n_checks++;
    if (!(last_rsp && last_fire)) begin
      n_errors++; $display("FAIL same_setup: rsp=%b fire=%b, expected 1 and 1", last_rsp, last_fire);
    end
    n_checks++;
    if (o_instr_valid !== 1'b0) begin
      n_errors++; $display("FAIL same_flush: valid=%b, expected 0", o_instr_valid);
    end
    n_checks++;
    if (o_imem_req_addr !== 32'h200) begin
      n_errors++; $display("FAIL same_align: addr=%h, expected 00000200", o_imem_req_addr);
    end
    dec_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    drain(100, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL same_drain: %0d left, expected 0", left);
    end
  endtask

  task automatic test_wrap_random();
    int left;
    lat = 2; mem_pct = 70; dec_pct = 60; dec_en = 1'b1;
    tick(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hFFFF_FFF8 + 32'(4 * i));
    drain(400, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL wrap_drain: %0d left, expected 0", left);
    end
    lat = $urandom_range(1, 3);
    tick(1'b1, 32'h0000_1000);
    for (int i = 0; i < 30; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    drain(2000, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL random_drain: %0d left, expected 0", left);
    end
  endtask

  task automatic test_reset_mid();
    int left;
    lat = 3; mem_pct = 100; dec_pct = 100; dec_en = 1'b0;
    do_reset();
    repeat (5) tick(1'b0, '0);
    n_checks++;
    if (pend_addr_q.size() != 2 || o_instr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_setup: outstanding=%0d valid=%b, expected 2 and 1", pend_addr_q.size(), o_instr_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_instr_valid !== 1'b0 || o_pc !== '0 || o_imem_req_addr !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: valid=%b pc=%h addr=%h, expected 0, 0, 0", o_instr_valid, o_pc, o_imem_req_addr);
    end
    @(negedge i_clk);
    cyc++;
    do_reset();
    n_checks++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL rstmid_restart: valid=%b addr=%h, expected 1 and 0", o_imem_req_valid, o_imem_req_addr);
    end
    dec_en = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    drain(100, left);
    n_checks++;
    if (left != 0) begin
      n_errors++; $display("FAIL rstmid_drain: %0d left, expected 0", left);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n          = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_instr_ready    = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_wrap_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
